// File: rtl/mac_feeder.sv
// mac_feeder: operand sequencer in front of the six parallel MAC lanes.
// For each output position of a 5x5 convolution it issues 25 pixel and
// weight read addresses, one tap per cycle. It forwards the returned
// operands to the MACs with enable/clear strobes. It then raises res_valid
// and waits for the post-MAC stage to accept the finished window.
// Layer 00 = conv1 (28x28, one channel broadcast to every lane).
// Layer 01 = conv2 (12x12, one channel per lane).
// Build option: define MAC_FEEDER_PERF_EN to add the perf_stall output.
// perf_stall counts the cycles a finished window waits with res_ready low.
module mac_feeder #(
   parameter int DATA_W  = 16,
   parameter int N_MAC   = 6,
   parameter int KERNEL  = 5,
   parameter int C1_IN_W = 28,
   parameter int C2_IN_W = 12
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [1:0]                layer,
   output logic                      busy,
   output logic                      done,
   output logic [9:0]                pix_addr,
   input  logic [N_MAC*DATA_W-1:0]   pix_rdata,
   output logic [4:0]                wgt_addr,
   input  logic [N_MAC*DATA_W-1:0]   wgt_rdata,
   output logic [N_MAC*DATA_W-1:0]   mac_a,
   output logic [N_MAC*DATA_W-1:0]   mac_w,
   output logic                      mac_en,
   output logic                      mac_clr,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [4:0]                out_row,
   output logic [4:0]                out_col
`ifdef MAC_FEEDER_PERF_EN
   ,
   output logic [15:0]               perf_stall
`endif
);

   // Kernel geometry as narrow constants so every compare has matching widths.
   localparam logic [4:0] LP_LAST_TAP = 5'(KERNEL * KERNEL - 1);
   localparam logic [2:0] LP_LAST_K   = 3'(KERNEL - 1);
   localparam logic [4:0] LP_KERNEL   = 5'(KERNEL);
   localparam logic [4:0] LP_C1_W     = 5'(C1_IN_W);
   localparam logic [4:0] LP_C2_W     = 5'(C2_IN_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_RESULT,
      ST_FINISH
   } state_t;

   // Sequencer state: current window position and tap inside the window.
   state_t     r_state;
   logic [4:0] r_tap;
   logic [2:0] r_kr;
   logic [2:0] r_kc;
   logic [4:0] r_row;
   logic [4:0] r_col;
   logic [4:0] r_in_w;
   logic       r_conv2;

   // Registered address and strobe outputs.
   logic [9:0] r_pix_addr;
   logic [4:0] r_wgt_addr;
   logic       r_mac_en;
   logic       r_mac_clr;

   // Next-state values produced by the combinational FSM process.
   state_t     w_state_next;
   logic [4:0] w_tap_next;
   logic [2:0] w_kr_next;
   logic [2:0] w_kc_next;
   logic [4:0] w_row_next;
   logic [4:0] w_col_next;
   logic [4:0] w_in_w_next;
   logic       w_conv2_next;

   // Last valid window origin: in_w - KERNEL (23 for conv1, 7 for conv2).
   logic [4:0] w_last_pos;
   logic       w_last_window;
   logic       w_issuing;
   logic       w_start_ok;

   // Address of the tap that will be issued in the next cycle.
   logic [9:0] w_addr_row;
   logic [9:0] w_addr_next;

   assign w_last_pos    = r_in_w - LP_KERNEL;
   assign w_last_window = (r_row == w_last_pos) && (r_col == w_last_pos);
   assign w_issuing     = (r_state == ST_ISSUE);
   assign w_start_ok    = (r_state == ST_IDLE) && start;

   // Next-state, window-walk and tap-walk logic.
   always_comb begin
      w_state_next = r_state;
      w_tap_next   = r_tap;
      w_kr_next    = r_kr;
      w_kc_next    = r_kc;
      w_row_next   = r_row;
      w_col_next   = r_col;
      w_in_w_next  = r_in_w;
      w_conv2_next = r_conv2;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (!layer[1]) begin
                  w_in_w_next  = layer[0] ? LP_C2_W : LP_C1_W;
                  w_conv2_next = layer[0];
                  w_row_next   = 5'd0;
                  w_col_next   = 5'd0;
                  w_tap_next   = 5'd0;
                  w_kr_next    = 3'd0;
                  w_kc_next    = 3'd0;
                  w_state_next = ST_ISSUE;
               end else begin
                  // Unsupported layer code: report completion without work.
                  w_state_next = ST_FINISH;
               end
            end
         end
         ST_ISSUE: begin
            if (r_tap == LP_LAST_TAP) begin
               w_state_next = ST_DRAIN;
            end else begin
               w_tap_next = r_tap + 5'd1;
               if (r_kc == LP_LAST_K) begin
                  w_kc_next = 3'd0;
                  w_kr_next = r_kr + 3'd1;
               end else begin
                  w_kc_next = r_kc + 3'd1;
               end
            end
         end
         ST_DRAIN: begin
            w_state_next = ST_RESULT;
         end
         ST_RESULT: begin
            if (res_ready) begin
               if (w_last_window) begin
                  w_state_next = ST_FINISH;
               end else begin
                  // Column advances fastest; wrap to the next row at the edge.
                  if (r_col == w_last_pos) begin
                     w_col_next = 5'd0;
                     w_row_next = r_row + 5'd1;
                  end else begin
                     w_col_next = r_col + 5'd1;
                  end
                  w_tap_next   = 5'd0;
                  w_kr_next    = 3'd0;
                  w_kc_next    = 3'd0;
                  w_state_next = ST_ISSUE;
               end
            end
         end
         ST_FINISH: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Pixel address of the next tap: (row + kr) * in_w + col + kc.
   // This is unsigned, and the worst case of 783 still fits in 10 bits.
   assign w_addr_row  = 10'(w_row_next) + 10'(w_kr_next);
   assign w_addr_next = (w_addr_row * 10'(w_in_w_next)) + 10'(w_col_next) + 10'(w_kc_next);

   // FSM state register plus window and tap counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_tap   <= 5'd0;
         r_kr    <= 3'd0;
         r_kc    <= 3'd0;
         r_row   <= 5'd0;
         r_col   <= 5'd0;
         r_in_w  <= LP_C1_W;
         r_conv2 <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tap   <= w_tap_next;
         r_kr    <= w_kr_next;
         r_kc    <= w_kc_next;
         r_row   <= w_row_next;
         r_col   <= w_col_next;
         r_in_w  <= w_in_w_next;
         r_conv2 <= w_conv2_next;
      end
   end

   // Read addresses load only when the next cycle issues a tap.
   // They hold their value at all other times, so the memories see no
   // address change while a result waits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_addr <= 10'd0;
         r_wgt_addr <= 5'd0;
      end else if (w_state_next == ST_ISSUE) begin
         r_pix_addr <= w_addr_next;
         r_wgt_addr <= w_tap_next;
      end
   end

   // MAC strobes trail the issue by one cycle, matching the memory read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mac_en  <= 1'b0;
         r_mac_clr <= 1'b0;
      end else begin
         r_mac_en  <= w_issuing;
         r_mac_clr <= w_issuing && (r_tap == 5'd0);
      end
   end

   // Per-lane operand steering. conv1 broadcasts channel 0 to every lane.
   // conv2 feeds each lane its own channel. Operands read zero when the
   // MACs are idle.
   genvar gi;
   generate
      for (gi = 0; gi < N_MAC; gi++) begin : g_lane
         logic [DATA_W-1:0] w_a_sel;
         assign w_a_sel = r_conv2 ? pix_rdata[gi*DATA_W +: DATA_W]
                                  : pix_rdata[DATA_W-1:0];
         assign mac_a[gi*DATA_W +: DATA_W] = r_mac_en ? w_a_sel : '0;
         assign mac_w[gi*DATA_W +: DATA_W] = r_mac_en ? wgt_rdata[gi*DATA_W +: DATA_W] : '0;
      end
   endgenerate

`ifdef MAC_FEEDER_PERF_EN
   logic [15:0] r_perf_stall;

   // Count result-wait cycles for the current layer. The count clears on
   // start and saturates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_stall <= 16'd0;
      end else if (w_start_ok) begin
         r_perf_stall <= 16'd0;
      end else if ((r_state == ST_RESULT) && !res_ready && (r_perf_stall != 16'hFFFF)) begin
         r_perf_stall <= r_perf_stall + 16'd1;
      end
   end

   assign perf_stall = r_perf_stall;
`endif

   assign busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN) || (r_state == ST_RESULT);
   assign done      = (r_state == ST_FINISH);
   assign res_valid = (r_state == ST_RESULT);
   assign pix_addr  = r_pix_addr;
   assign wgt_addr  = r_wgt_addr;
   assign mac_en    = r_mac_en;
   assign mac_clr   = r_mac_clr;
   assign out_row   = r_row;
   assign out_col   = r_col;

endmodule

// File: tb/tb_mac_feeder.sv
// Testbench for mac_feeder.
// Random pixel and weight memories feed the DUT. The model is a per-layer
// list of expected windows and operand beats, built directly from the
// convolution definition. It also tracks the expected busy/done timing.
// One compare process checks the DUT against this model on every cycle.
`timescale 1ns/1ps
module tb_mac_feeder;
   localparam int DW = 16;
   localparam int NM = 6;
   localparam int LW = NM * DW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [1:0]    layer;
   logic          busy, done;
   logic [9:0]    pix_addr;
   logic [LW-1:0] pix_rdata;
   logic [4:0]    wgt_addr;
   logic [LW-1:0] wgt_rdata;
   logic [LW-1:0] mac_a, mac_w;
   logic          mac_en, mac_clr, res_valid, res_ready;
   logic [4:0]    out_row, out_col;
`ifdef MAC_FEEDER_PERF_EN
   logic [15:0]   perf_stall;
`endif

   always #5 clk = ~clk;

   mac_feeder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .layer     (layer),
      .busy      (busy),
      .done      (done),
      .pix_addr  (pix_addr),
      .pix_rdata (pix_rdata),
      .wgt_addr  (wgt_addr),
      .wgt_rdata (wgt_rdata),
      .mac_a     (mac_a),
      .mac_w     (mac_w),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .out_row   (out_row),
      .out_col   (out_col)
`ifdef MAC_FEEDER_PERF_EN
      ,
      .perf_stall(perf_stall)
`endif
   );

   // Synchronous memories with one cycle of read latency.
   logic [LW-1:0] pix_mem [0:1023];
   logic [LW-1:0] wgt_mem [0:31];
   always @(posedge clk) begin
      pix_rdata <= pix_mem[pix_addr];
      wgt_rdata <= wgt_mem[wgt_addr];
   end

   typedef struct packed {
      logic [LW-1:0] a;
      logic [LW-1:0] w;
      logic          clr;
   } beat_t;
   typedef struct packed {
      logic [4:0] row;
      logic [4:0] col;
   } win_t;

   beat_t beat_q[$];
   win_t  win_q[$];

   int total = 0, bad = 0;
   int cyc = 0;
   int win_acc = 0, beats = 0, done_cnt = 0;
   int start_cyc = 0, last_acc_cyc = 0, clr_cyc = 0, done_due = -1, done_cyc = 0;
   int rv_w3 = 0, stall_model = 0, stall_left = 0, ready_mode = 0;
   bit model_on = 0, busy_flag = 0, prev_rv = 0;
   logic [9:0] prev_pix = '0;
   logic [4:0] prev_wgt = '0, prev_row = '0, prev_col = '0;
   int first_addr [0:575];
   int w0_addr [0:24];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected windows and operand beats, built from the convolution definition.
   task automatic build_model(input int lay);
      int w;
      int addr;
      beat_t b;
      win_t  wn;
      logic [LW-1:0] word;
      w = (lay == 1) ? 12 : 28;
      beat_q.delete();
      win_q.delete();
      for (int r = 0; r < w - 4; r++) begin
         for (int c = 0; c < w - 4; c++) begin
            wn.row = 5'(r);
            wn.col = 5'(c);
            win_q.push_back(wn);
            for (int t = 0; t < 25; t++) begin
               addr = (r + t / 5) * w + c + t % 5;
               word = pix_mem[addr];
               for (int l = 0; l < NM; l++)
                  b.a[l*DW +: DW] = (lay == 1) ? word[l*DW +: DW] : word[DW-1:0];
               b.w   = wgt_mem[t];
               b.clr = (t == 0);
               beat_q.push_back(b);
            end
         end
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin : cmp_proc
      beat_t bt;
      win_t  wt;
      cyc++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (model_on) begin
         check("busy", busy, busy_flag);
         check("done", done, cyc == done_due);
`ifdef MAC_FEEDER_PERF_EN
         if (done) check("perf_stall", perf_stall, stall_model);
`endif
         if (mac_en) begin
            check("res_valid_during_mac", res_valid, 0);
            if (beat_q.size() == 0) begin
               check("mac_en_unexpected", mac_en, 0);
            end else begin
               bt = beat_q.pop_front();
               check("mac_a", mac_a, bt.a);
               check("mac_w", mac_w, bt.w);
               check("mac_clr", mac_clr, bt.clr);
               check("wgt_addr_tap", prev_wgt, beats);
               if (win_acc == 0) w0_addr[beats] = int'(prev_pix);
               if (bt.clr) begin
                  if (win_acc < 576) first_addr[win_acc] = int'(prev_pix);
                  check("issue_latency", cyc, (win_acc == 0) ? start_cyc + 2 : last_acc_cyc + 2);
                  clr_cyc = cyc;
               end
               beats++;
            end
         end
         if (res_valid && !prev_rv) check("result_latency", cyc, clr_cyc + 25);
         if (res_valid && prev_rv) begin
            check("stall_row_stable", out_row, prev_row);
            check("stall_col_stable", out_col, prev_col);
            check("stall_pix_stable", pix_addr, prev_pix);
            check("stall_wgt_stable", wgt_addr, prev_wgt);
         end
         if (res_valid) begin
            if (win_acc == 3) rv_w3++;
            if (!res_ready && stall_model < 65535) stall_model++;
         end
         if (res_valid && res_ready) begin
            if (win_q.size() == 0) begin
               check("extra_window", res_valid, 0);
            end else begin
               wt = win_q.pop_front();
               check("out_row", out_row, wt.row);
               check("out_col", out_col, wt.col);
               check("beats_per_window", beats, 25);
               beats = 0;
               last_acc_cyc = cyc;
               win_acc++;
               if (win_q.size() == 0) begin
                  busy_flag = 0;
                  done_due  = cyc + 1;
               end
            end
         end
         if (start && !busy_flag && done_due < cyc) begin
            start_cyc   = cyc;
            stall_model = 0;
            if (!layer[1]) busy_flag = 1;
            else           done_due  = cyc + 1;
         end
      end
      prev_rv  = res_valid;
      prev_pix = pix_addr;
      prev_wgt = wgt_addr;
      prev_row = out_row;
      prev_col = out_col;
   end

   // res_ready driver: always high, random, or a 10-cycle hold on window 3.
   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: res_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (res_valid && win_acc == 3 && stall_left > 0) begin
                  res_ready = 1'b0;
                  stall_left--;
               end else if (win_acc == 3) begin
                  res_ready = 1'b1;
               end else begin
                  res_ready = ($urandom_range(0, 3) != 0);
               end
            end
            default: res_ready = 1'b1;
         endcase
      end
   end

   task automatic run_layer(input logic [1:0] lay, input bit repulse, input string tag);
      int d0;
      build_model(int'(lay));
      win_acc = 0;
      beats   = 0;
      rv_w3   = 0;
      d0      = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      layer = lay;
      @(posedge clk); #1;
      start = 1'b0;
      layer = 2'($urandom_range(0, 3));
      if (repulse) begin
         repeat (100) @(posedge clk);
         #1;
         start = 1'b1;
         layer = 2'b01;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < 40000 && done_cnt == d0; i++) @(posedge clk);
      if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
      #1;
      check({tag, "_beats_left"}, beat_q.size(), 0);
      check({tag, "_windows_left"}, win_q.size(), 0);
      $display("run %s: windows=%0d cycles=%0d", tag, win_acc, done_cyc - start_cyc);
   endtask

   initial begin
      int d0;
      bit hit;
      for (int i = 0; i < 1024; i++) pix_mem[i] = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 32; i++)   wgt_mem[i] = {$urandom, $urandom, $urandom};
      reset_n = 1'b0;
      start   = 1'b0;
      layer   = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_mac_clr", mac_clr, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_pix_addr", pix_addr, 0);
      check("rst_out_row", out_row, 0);
      check("rst_mac_a", mac_a, 0);
      reset_n  = 1'b1;
      model_on = 1;
      repeat (2) @(posedge clk);

      // conv1, res_ready high, plus a second start while busy.
      ready_mode = 0;
      run_layer(2'b00, 1, "conv1");
      check("conv1_windows", win_acc, 576);
      check("conv1_done_latency", done_cyc - start_cyc, 27 * 576 + 1);
      check("conv1_w0_tap0", first_addr[0], 0);
      check("conv1_w0_tap4", w0_addr[4], 4);
      check("conv1_w0_tap5", w0_addr[5], 28);
      check("conv1_w0_tap24", w0_addr[24], 116);
      check("conv1_last_first_addr", first_addr[575], 667);

      // conv2, res_ready high.
      run_layer(2'b01, 0, "conv2");
      check("conv2_windows", win_acc, 64);
      check("conv2_done_latency", done_cyc - start_cyc, 27 * 64 + 1);
      check("conv2_row1_col0_addr", first_addr[8], 12);
      check("conv2_w0_tap24", w0_addr[24], 52);

      // conv2 with a 10-cycle hold on window 3 and random ready elsewhere.
      ready_mode = 2;
      stall_left = 10;
      run_layer(2'b01, 0, "conv2_stall");
      check("stall_w3_valid_cycles", rv_w3, 11);
      check("stall_windows", win_acc, 64);
      ready_mode = 0;

      // Unsupported layer code.
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      layer = 2'b10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      check("bad_layer_done_count", done_cnt - d0, 1);
      check("bad_layer_done_latency", done_cyc - start_cyc, 1);
      $display("run bad_layer: done pulses=%0d", done_cnt - d0);

      // Reset at tap 12 of window 5 of conv1.
      build_model(0);
      win_acc = 0;
      beats   = 0;
      d0      = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      layer = 2'b00;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge clk); #2;
         hit = (win_acc == 5 && beats == 12);
      end
      check("abort_reached", hit, 1);
      check("abort_pre_col", out_col, 5);
      model_on = 0;
      reset_n  = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_mac_en", mac_en, 0);
      check("abort_mac_clr", mac_clr, 0);
      check("abort_res_valid", res_valid, 0);
      check("abort_pix_addr", pix_addr, 0);
      check("abort_wgt_addr", wgt_addr, 0);
      check("abort_out_row", out_row, 0);
      check("abort_out_col", out_col, 0);
      check("abort_mac_a", mac_a, 0);
      check("abort_mac_w", mac_w, 0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      $display("run abort: reset applied after %0d windows", win_acc);
      beat_q.delete();
      win_q.delete();
      busy_flag = 0;
      done_due  = -1;
      reset_n   = 1'b1;
      model_on  = 1;
      repeat (2) @(posedge clk);

      // Fresh conv1 after the abort starts again at row 0, column 0.
      run_layer(2'b00, 0, "conv1_restart");
      check("restart_windows", win_acc, 576);
      check("restart_first_addr", first_addr[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
